// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access arbiter slice.
package mem_ctrl_pkg;

    localparam int unsigned MEM_AW = 4;
    localparam int unsigned MEM_DW = 16;
    localparam int unsigned ID_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first asserted request at or after ptr, wrapping.
module rr_picker
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            any,
    output logic [ID_W-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest match is written last.
    always_comb begin
        any = |req;
        idx = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req[i] && (i == ((int'(ptr) + k) % int'(NREQ)))) begin
                    idx = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter serializing NREQ requesters onto one single-port memory.
module mem_access_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = MEM_AW,
    parameter int unsigned DW   = MEM_DW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [DW-1:0]      rsp_rdata,
    output logic               mem_wr_en,
    output logic               mem_rd_en,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
);

    state_t          state_q;
    state_t          state_d;
    logic [ID_W-1:0] grant_q;
    logic [ID_W-1:0] ptr_q;
    logic            pick_any;
    logic [ID_W-1:0] pick_idx;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req (req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Request fields of the latched winner.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = GRANT;
            GRANT:   state_d = sel_we ? IDLE : RD_WAIT;
            RD_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes and accept exist only in GRANT; everything else holds at zero.
    always_comb begin
        req_ready = '0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == GRANT) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                req_ready[i] = (grant_q == ID_W'(i));
            end
            mem_wr_en = sel_we;
            mem_rd_en = ~sel_we;
            mem_addr  = sel_addr;
            mem_wdata = sel_wdata;
        end
    end

    // Winner, rotation pointer and read response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q   <= '0;
            ptr_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if ((state_q == IDLE) && pick_any) begin
                grant_q <= pick_idx;
            end
            if (state_q == GRANT) begin
                ptr_q <= (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + ID_W'(1);
            end
            if (state_q == RD_WAIT) begin
                rsp_valid <= 1'b1;
                rsp_id    <= grant_q;
                rsp_rdata <= mem_rdata;
            end
        end
    end

endmodule
